// File: rtl/panda_pkg.sv
// ----------------------------------------------------------------------------
// panda_pkg
// Shared types for the panda pipeline hazard controller.
//   hazard_state_e : state of the data-memory handshake sequencer
//   is_wait_state  : true while an access is outstanding (counted against
//                    the timeout)
// ----------------------------------------------------------------------------
package panda_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } hazard_state_e;

    function automatic logic is_wait_state(input hazard_state_e s);
        return (s == WAIT_GNT) || (s == WAIT_RVALID);
    endfunction

endpackage

// File: rtl/panda_sat_counter.sv
// ----------------------------------------------------------------------------
// panda_sat_counter
// Free-running event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i   in  1      clock
//   rst_ni  in  1      asynchronous active-low reset, clears the count
//   inc_i   in  1      count this cycle
//   count_o out CNT_W  current count
// ----------------------------------------------------------------------------
module panda_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Hold at all-ones once reached so the perf count never wraps to a
    // misleadingly small value.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/panda_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// panda_hazard_ctrl
// Pipeline hazard and stall controller. Detects load-use hazards in ID,
// flushes wrong-path instructions on a taken branch resolved in EX, and
// sequences the MEM-stage data-memory req/gnt/rvalid handshake, holding the
// pipeline while an access is outstanding. An access that waits too long is
// abandoned with a one-cycle error pulse.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   if_id_rs1/rs2_addr_i, *_used_i       source registers of the ID instr
//   id_ex_rd_addr_i, id_ex_rd_we_i,
//   id_ex_load_i                         destination/kind of the EX instr
//   branch_taken_i                       EX resolved a taken branch/jump
//   ex_mem_req_i, ex_mem_load_i          MEM instr accesses dmem (load/store)
//   dmem_req_o, dmem_gnt_i, dmem_rvalid_i data-memory handshake
//   pc/if_id/id_ex/ex_mem_stall_o        hold the corresponding register
//   if_id/id_ex/ex_mem/mem_wb_flush_o    load a bubble into the register
//   mem_err_o                            pulse when an access times out
//   stall_cnt_o                          saturating count of PC-stall cycles
// ----------------------------------------------------------------------------
module panda_hazard_ctrl
    import panda_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       if_id_rs1_addr_i,
    input  logic [4:0]       if_id_rs2_addr_i,
    input  logic             if_id_rs1_used_i,
    input  logic             if_id_rs2_used_i,
    input  logic [4:0]       id_ex_rd_addr_i,
    input  logic             id_ex_rd_we_i,
    input  logic             id_ex_load_i,
    input  logic             branch_taken_i,
    input  logic             ex_mem_req_i,
    input  logic             ex_mem_load_i,
    output logic             dmem_req_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wide enough to hold MEM_TIMEOUT-1; the timeout forces an exit before
    // the counter could ever wrap.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_e     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic timeout;
    logic load_use;

    // Handshake sequencer and wait counter. A timeout overrides whatever the
    // handshake would have done and drops the access.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = ex_mem_req_i & (~dmem_gnt_i | ex_mem_load_i);
                if (ex_mem_req_i && !dmem_gnt_i) begin
                    state_d = WAIT_GNT;
                end else if (ex_mem_req_i && dmem_gnt_i && ex_mem_load_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_GNT: begin
                mem_stall = ex_mem_req_i & (~dmem_gnt_i | ex_mem_load_i);
                if (dmem_gnt_i) begin
                    state_d = ex_mem_load_i ? WAIT_RVALID : IDLE;
                end
            end
            WAIT_RVALID: begin
                mem_stall = ~dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        timeout = is_wait_state(state_q) && (wait_cnt_q == WAIT_LAST);
        if (timeout) begin
            state_d = IDLE;
        end

        if ((state_d != state_q) || (state_q == IDLE)) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // rd==x0 never creates a real dependency.
    assign load_use = id_ex_load_i & id_ex_rd_we_i & (id_ex_rd_addr_i != 5'd0) &
                      ((if_id_rs1_used_i & (if_id_rs1_addr_i == id_ex_rd_addr_i)) |
                       (if_id_rs2_used_i & (if_id_rs2_addr_i == id_ex_rd_addr_i)));

    // Priority mux. During a memory stall the taken branch stays held in EX
    // and is acted on once the pipeline moves again; a branch squashes the
    // ID instruction, so its load-use hazard is irrelevant.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        mem_err_o      = 1'b0;
        if (timeout) begin
            mem_err_o      = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (mem_stall) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    // A request is never re-issued while its response is pending.
    assign dmem_req_o = ex_mem_req_i & (state_q != WAIT_RVALID);

    panda_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (pc_stall_o),
        .count_o (stall_cnt_o)
    );

endmodule
